// File: rtl/door_sequencer_if.sv
// Pad-side bundle for the door sequencer.
// master: pad/board side; drives ena, req, sen, la, lc, fault_clr and observes the motor commands.
// slave : the sequencer; consumes the pad inputs and drives ma, mc, state, grant, fault.
interface door_sequencer_if;
  logic       ena;        // 0 freezes the sequencer
  logic [2:0] req;        // level open requests: [0] inside, [1] outside, [2] remote
  logic       sen;        // presence/obstruction sensor
  logic       la;         // open-limit switch
  logic       lc;         // close-limit switch
  logic       fault_clr;  // fault acknowledge
  logic       ma;         // motor open command
  logic       mc;         // motor close command
  logic [2:0] state;      // current state code
  logic [2:0] grant;      // one-hot owner of the current open cycle
  logic       fault;      // high while in FAULT

  modport master (
    output ena, req, sen, la, lc, fault_clr,
    input  ma, mc, state, grant, fault
  );

  modport slave (
    input  ena, req, sen, la, lc, fault_clr,
    output ma, mc, state, grant, fault
  );
endinterface

// File: rtl/door_sequencer.sv
// Motion sequencer for a single-door actuator.
// Arbitrates open requests from three sources, drives open/close motor commands from the limit
// switches and presence sensor, enforces a dwell before auto-close, reverses on obstruction and
// latches a fault on travel timeout, inconsistent limits or too many reversals.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - door_sequencer_if.slave: ena/req/sen/la/lc/fault_clr in; ma/mc/state/grant/fault out
module door_sequencer #(
  parameter int unsigned DWELL_CYC   = 1000,
  parameter int unsigned TRAVEL_MAX  = 5000,
  parameter int unsigned BLOCK_RETRY = 3
) (
  input logic                    clk,
  input logic                    rst,
  door_sequencer_if.slave        bus
);

  localparam int unsigned TW = $clog2(TRAVEL_MAX) + 1;
  localparam int unsigned DW = $clog2(DWELL_CYC) + 1;
  localparam int unsigned RW = $clog2(BLOCK_RETRY) + 1;

  localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_MAX - 1);
  localparam logic [DW-1:0] DwellLast  = DW'(DWELL_CYC - 1);
  localparam logic [RW-1:0] RetryLimit = RW'(BLOCK_RETRY);

  typedef enum logic [2:0] {
    StClosed  = 3'd0,
    StOpening = 3'd1,
    StOpen    = 3'd2,
    StClosing = 3'd3,
    StFault   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    grant_q, grant_d;

  logic activity;
  logic limits_bad;

  assign activity   = bus.sen | (|bus.req);
  assign limits_bad = bus.la & bus.lc;

  // State and counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClosed;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      grant_q <= grant_d;
    end
  end

  // Next state and counters. Everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    grant_d = grant_q;

    if (bus.ena) begin
      case (state_q)
        StClosed: begin
          if (|bus.req) begin
            state_d = StOpening;
            // Fixed priority: inside > outside > remote.
            if (bus.req[0])      grant_d = 3'b001;
            else if (bus.req[1]) grant_d = 3'b010;
            else                 grant_d = 3'b100;
          end
        end
        StOpening: begin
          if (limits_bad)                 state_d = StFault;
          else if (bus.la)                state_d = StOpen;
          else if (tcnt_q == TravelLast)  state_d = StFault;
        end
        StOpen: begin
          if (activity)                   dcnt_d  = '0;
          else if (dcnt_q == DwellLast)   state_d = StClosing;
          else                            dcnt_d  = dcnt_q + DW'(1);
        end
        StClosing: begin
          if (limits_bad) begin
            state_d = StFault;
          end else if (activity) begin
            // Obstruction wins over lc; reopen unless the retry budget is spent.
            if (rcnt_q == RetryLimit) begin
              state_d = StFault;
            end else begin
              rcnt_d  = rcnt_q + RW'(1);
              state_d = StOpening;
            end
          end else if (bus.lc) begin
            state_d = StClosed;
            grant_d = '0;
          end else if (tcnt_q == TravelLast) begin
            state_d = StFault;
          end
        end
        StFault: begin
          if (bus.fault_clr) state_d = StOpening;
        end
        default: state_d = StFault;  // unreachable codes 5..7
      endcase

      // Entry actions; the travel counter runs only while staying in a stroke.
      if (state_d != state_q) begin
        if (state_d == StOpening || state_d == StClosing) tcnt_d = '0;
        if (state_d == StOpen)                            dcnt_d = '0;
        if (state_d == StClosed || state_d == StFault)    rcnt_d = '0;
        if (state_d == StFault)                           grant_d = '0;
      end else if (state_q == StOpening || state_q == StClosing) begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // Moore outputs straight from the state register, so reset kills the motor asynchronously.
  always_comb begin
    bus.ma    = (state_q == StOpening);
    bus.mc    = (state_q == StClosing);
    bus.fault = (state_q == StFault);
    bus.state = state_q;
    bus.grant = grant_q;
  end

endmodule

// File: tb/tb_door_sequencer.sv
module tb_door_sequencer;
  localparam int unsigned DW = 4;
  localparam int unsigned TM = 8;
  localparam int unsigned BR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  door_sequencer_if dif ();

  door_sequencer #(
    .DWELL_CYC  (DW),
    .TRAVEL_MAX (TM),
    .BLOCK_RETRY(BR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: state code per the state table, plus plain cycle tallies.
  int m_state;   // 0 closed, 1 opening, 2 open, 3 closing, 4 fault
  int m_grant;
  int m_travel;  // cycles already spent in the current stroke
  int m_idle;    // consecutive idle cycles in OPEN
  int m_rev;     // reversals since last CLOSED/FAULT

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_grant = 0; m_travel = 0; m_idle = 0; m_rev = 0;
  endtask

  task automatic model_step(input logic e, input logic [2:0] r, input logic s, input logic a,
                            input logic c, input logic fc);
    int ns;
    bit act;
    bit bad;
    if (!e) return;
    act = s || (r != 3'b000);
    bad = a && c;
    ns  = m_state;
    case (m_state)
      0: if (r != 3'b000) begin
           ns = 1;
           m_grant = r[0] ? 1 : (r[1] ? 2 : 4);
         end
      1: if (bad) ns = 4;
         else if (a) ns = 2;
         else if (m_travel == TM - 1) ns = 4;
      2: if (act) m_idle = 0;
         else if (m_idle == DW - 1) ns = 3;
         else m_idle = m_idle + 1;
      3: if (bad) ns = 4;
         else if (act) begin
           if (m_rev == BR) ns = 4;
           else begin m_rev = m_rev + 1; ns = 1; end
         end
         else if (c) ns = 0;
         else if (m_travel == TM - 1) ns = 4;
      4: if (fc) ns = 1;
      default: ns = 4;
    endcase
    if (ns != m_state) begin
      m_travel = 0;
      m_idle   = 0;
      if (ns == 0 || ns == 4) begin m_rev = 0; m_grant = 0; end
    end else begin
      m_travel = m_travel + 1;
    end
    m_state = ns;
  endtask

  // Compare process: full output check against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {29'd0, dif.state}, m_state);
      check("ma", {31'd0, dif.ma}, (m_state == 1) ? 1 : 0);
      check("mc", {31'd0, dif.mc}, (m_state == 3) ? 1 : 0);
      check("fault", {31'd0, dif.fault}, (m_state == 4) ? 1 : 0);
      check("grant", {29'd0, dif.grant}, m_grant);
    end
  end

  // One clock: drive after the falling edge, advance the model at the rising edge, settle 1.
  task automatic tick(input logic e, input logic [2:0] r, input logic s, input logic a,
                      input logic c, input logic fc);
    @(negedge clk);
    dif.ena = e; dif.req = r; dif.sen = s; dif.la = a; dif.lc = c; dif.fault_clr = fc;
    @(posedge clk);
    model_step(e, r, s, a, c, fc);
    #1;
  endtask

  task automatic idle_open(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic random_tick();
    logic e, s, a, c, fc;
    logic [2:0] r;
    e  = ($urandom_range(15) != 0);
    r  = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
    s  = ($urandom_range(7) == 0);
    a  = ($urandom_range(4) == 0);
    c  = ($urandom_range(4) == 0);
    fc = ($urandom_range(3) == 0);
    tick(e, r, s, a, c, fc);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    dif.ena = 1'b1; dif.req = '0; dif.sen = 1'b0; dif.la = 1'b0; dif.lc = 1'b1;
    dif.fault_clr = 1'b0;
    model_reset();
    #12;
    check("rst_state", {29'd0, dif.state}, 0);
    check("rst_ma", {31'd0, dif.ma}, 0);
    check("rst_mc", {31'd0, dif.mc}, 0);
    check("rst_grant", {29'd0, dif.grant}, 0);
    check("rst_fault", {31'd0, dif.fault}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Full cycle: outside+remote request, outside wins.
    tick(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_grant", {29'd0, dif.grant}, 3'b010);
    check("full_ma", {31'd0, dif.ma}, 1);
    check("model_grant", m_grant, 2);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_open", {29'd0, dif.state}, 2);
    idle_open(3);
    check("full_dwell3", {31'd0, dif.mc}, 0);
    idle_open(1);
    check("full_dwell4", {31'd0, dif.mc}, 1);
    check("model_closing", m_state, 3);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_closed", {29'd0, dif.state}, 0);
    check("full_grant0", {29'd0, dif.grant}, 0);

    // Dwell restart on a sensor pulse at dcnt=2.
    tick(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_open(2);
    tick(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_open(3);
    check("dwell_hold", {29'd0, dif.state}, 2);
    idle_open(1);
    check("dwell_close", {29'd0, dif.state}, 3);

    // Reversals: two reopen, the third faults.
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
      check("rev_reopen", {29'd0, dif.state}, 1);
      check("rev_grant", {29'd0, dif.grant}, 3'b001);
      tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_open(4);
    end
    tick(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rev_fault", {31'd0, dif.fault}, 1);
    check("rev_ma", {31'd0, dif.ma}, 0);
    check("rev_mc", {31'd0, dif.mc}, 0);
    check("model_fault", m_state, 4);

    // Timeout: clear fault, hold la low, count the stroke.
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_fault", {31'd0, dif.fault}, 0);
    n = 0;
    for (int i = 0; i < 20 && dif.fault == 1'b0; i++) begin
      if (dif.ma) n++;
      tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("stroke_len", n, 8);
    check("timeout_fault", {31'd0, dif.fault}, 1);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("timeout_clr", {29'd0, dif.state}, 1);

    // ena=0 freezes the travel counter mid-stroke.
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1);
    check("ena_hold", {31'd0, dif.ma}, 1);
    for (int i = 0; i < 4; i++) tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ena_notimeout", {29'd0, dif.state}, 1);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ena_timeout", {29'd0, dif.state}, 4);

    // Inconsistent limits while opening; obstruction beats lc while closing.
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("limits_bad", {29'd0, dif.state}, 4);
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_open(4);
    tick(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sen_beats_lc", {29'd0, dif.state}, 1);

    // Asynchronous reset in CLOSING drops mc before the next edge.
    tick(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_open(4);
    check("pre_rst_mc", {31'd0, dif.mc}, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_mc", {31'd0, dif.mc}, 0);
    check("async_state", {29'd0, dif.state}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) random_tick();

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
